// File: rtl/cv32e40p_obi_arb_pkg.sv
// Shared types for the two-master OBI data-port arbiter: master IDs and the muxed request bundle.
// The request bundle carries up to OBI_ADDR_WIDTH address bits.
package cv32e40p_obi_arb_pkg;

  localparam int unsigned OBI_ADDR_WIDTH = 32;

  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  typedef struct packed {
    logic [OBI_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [3:0]                be;
    logic [31:0]               wdata;
  } obi_req_t;

  function automatic master_id_t other_master(input master_id_t id);
    return (id == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/cv32e40p_obi_arb_id_fifo.sv
// In-order FIFO of granted master IDs; the head names the owner of the next slave response.
// Pushes while full and pops while empty are ignored.
module cv32e40p_obi_arb_id_fifo
  import cv32e40p_obi_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  master_id_t push_id_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output master_id_t head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  master_id_t       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_r == CNT_W'(DEPTH));
  assign empty_o = (cnt_r == '0);
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign head_o  = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage; contents are only observed while the FIFO is non-empty
  always_ff @(posedge clk_i) begin
    if (push_s) mem_r[wr_ptr_r] <= push_id_i;
  end

endmodule

// File: rtl/cv32e40p_obi_data_arbiter.sv
// Two-master round-robin arbiter onto one OBI data port with in-order response routing.
// Optional grant counters are built when OBI_ARB_GRANT_CNT_EN is defined.
module cv32e40p_obi_data_arbiter
  import cv32e40p_obi_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  s_req_o,
  input  logic                  s_gnt_i,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [31:0]           s_wdata_o,
  input  logic                  s_rvalid_i,
  input  logic [31:0]           s_rdata_i,
  output logic                  err_o,
  output logic [31:0]           cnt_m0_o,
  output logic [31:0]           cnt_m1_o
);

  obi_req_t   m0_bundle_s;
  obi_req_t   m1_bundle_s;
  obi_req_t   sel_bundle_s;
  master_id_t sel_s;
  master_id_t rr_r;
  master_id_t lock_id_r;
  master_id_t head_s;
  logic       lock_r;
  logic       lock_live_s;
  logic       err_r;
  logic       req_s;
  logic       grant_s;
  logic       full_s;
  logic       empty_s;

  assign m0_bundle_s = '{addr: OBI_ADDR_WIDTH'(m0_addr_i), we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
  assign m1_bundle_s = '{addr: OBI_ADDR_WIDTH'(m1_addr_i), we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};

  assign lock_live_s = lock_r & ((lock_id_r == M1) ? m1_req_i : m0_req_i);

  // Master selection: a held (ungranted) request keeps the port, otherwise round-robin
  always_comb begin
    sel_s = M0;
    if (lock_live_s) begin
      sel_s = lock_id_r;
    end else if (m0_req_i && m1_req_i) begin
      sel_s = rr_r;
    end else if (m1_req_i) begin
      sel_s = M1;
    end else begin
      sel_s = M0;
    end
  end

  assign sel_bundle_s = (sel_s == M1) ? m1_bundle_s : m0_bundle_s;
  assign req_s        = (m0_req_i | m1_req_i) & ~full_s;
  assign grant_s      = req_s & s_gnt_i;

  assign s_req_o   = req_s;
  assign s_addr_o  = ADDR_WIDTH'(sel_bundle_s.addr);
  assign s_we_o    = sel_bundle_s.we;
  assign s_be_o    = sel_bundle_s.be;
  assign s_wdata_o = sel_bundle_s.wdata;
  assign m0_gnt_o  = grant_s & (sel_s == M0);
  assign m1_gnt_o  = grant_s & (sel_s == M1);

  assign m0_rvalid_o = s_rvalid_i & ~empty_s & (head_s == M0);
  assign m1_rvalid_o = s_rvalid_i & ~empty_s & (head_s == M1);
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign err_o       = err_r;

  cv32e40p_obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (grant_s),
    .push_id_i (sel_s),
    .pop_i     (s_rvalid_i),
    .full_o    (full_s),
    .empty_o   (empty_s),
    .head_o    (head_s)
  );

  // Round-robin pointer, address-phase lock and sticky orphan-response flag
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_r      <= M0;
      lock_r    <= 1'b0;
      lock_id_r <= M0;
      err_r     <= 1'b0;
    end else begin
      if (grant_s) rr_r <= other_master(sel_s);
      lock_r    <= req_s & ~s_gnt_i;
      lock_id_r <= sel_s;
      if (s_rvalid_i && empty_s) err_r <= 1'b1;
    end
  end

`ifdef OBI_ARB_GRANT_CNT_EN
  logic [31:0] cnt_m0_r;
  logic [31:0] cnt_m1_r;

  // Per-master grant counters, wrapping at 2^32
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_m0_r <= 32'h0;
      cnt_m1_r <= 32'h0;
    end else begin
      if (m0_gnt_o) cnt_m0_r <= cnt_m0_r + 32'd1;
      if (m1_gnt_o) cnt_m1_r <= cnt_m1_r + 32'd1;
    end
  end

  assign cnt_m0_o = cnt_m0_r;
  assign cnt_m1_o = cnt_m1_r;
`else
  assign cnt_m0_o = 32'h0;
  assign cnt_m1_o = 32'h0;
`endif

endmodule

// File: tb/tb_cv32e40p_obi_data_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts every cycle's outputs, a monitor compares.
module tb_cv32e40p_obi_data_arbiter;

  localparam int MAXO = 2;
`ifdef OBI_ARB_GRANT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_i, m1_req_i, m0_gnt_o, m1_gnt_o;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i, err_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i, cnt_m0_o, cnt_m1_o;
  logic [3:0]  s_be_o;

  always #5 clk_i = ~clk_i;

  cv32e40p_obi_data_arbiter #(.MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .err_o(err_o), .cnt_m0_o(cnt_m0_o), .cnt_m1_o(cnt_m1_o)
  );

  typedef struct {
    bit          chk;
    bit          sreq;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          g0, g1, rv0, rv1, err;
    logic [31:0] rdata, c0, c1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state: who owns outstanding responses, in order
  bit          outq[$];
  bit          m_rr, m_lock, m_lock_id, m_err;
  int unsigned m_c0, m_c1;
  bit          last_g0, last_g1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
    m0_addr_i = 32'h0; m1_addr_i = 32'h0; m0_we_i = 1'b0; m1_we_i = 1'b0;
    m0_be_i = 4'h0; m1_be_i = 4'h0; m0_wdata_i = 32'h0; m1_wdata_i = 32'h0; s_rdata_i = 32'h0;
  endtask

  // Predict this cycle's outputs from the current inputs, then advance the model
  task automatic predict();
    exp_t e;
    bit   full, sel, grant, id;
    e = '{default: 0};
    e.chk = rst_ni;
    full = (outq.size() == MAXO);
    if (m_lock && (m_lock_id ? m1_req_i : m0_req_i)) sel = m_lock_id;
    else if (m0_req_i && m1_req_i) sel = m_rr;
    else sel = m1_req_i;
    e.sreq  = (m0_req_i || m1_req_i) && !full;
    grant   = e.sreq && s_gnt_i;
    e.addr  = sel ? m1_addr_i : m0_addr_i;
    e.we    = sel ? m1_we_i : m0_we_i;
    e.be    = sel ? m1_be_i : m0_be_i;
    e.wdata = sel ? m1_wdata_i : m0_wdata_i;
    e.g0    = grant && !sel;
    e.g1    = grant && sel;
    e.err   = m_err;
    e.c0    = CNT_EN ? m_c0 : 32'h0;
    e.c1    = CNT_EN ? m_c1 : 32'h0;
    e.rdata = s_rdata_i;
    if (s_rvalid_i) begin
      if (outq.size() > 0) begin
        id = outq.pop_front();
        e.rv0 = !id;
        e.rv1 = id;
      end else begin
        m_err = 1'b1;
      end
    end
    if (grant) begin
      outq.push_back(sel);
      m_rr = !sel;
      if (sel) m_c1++; else m_c0++;
    end
    m_lock    = e.sreq && !s_gnt_i;
    m_lock_id = sel;
    last_g0   = e.g0;
    last_g1   = e.g1;
    exp_q.push_back(e);
    if (!rst_ni) begin
      outq.delete();
      m_rr = 0; m_lock = 0; m_lock_id = 0; m_err = 0; m_c0 = 0; m_c1 = 0;
    end
  endtask

  // Monitor: compare the DUT against the predicted record of the current cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          chk("s_req", s_req_o, e.sreq);
          if (e.sreq) begin
            chk("s_addr", s_addr_o, e.addr);
            chk("s_we", s_we_o, e.we);
            chk("s_be", s_be_o, e.be);
            chk("s_wdata", s_wdata_o, e.wdata);
          end
          chk("m0_gnt", m0_gnt_o, e.g0);
          chk("m1_gnt", m1_gnt_o, e.g1);
          chk("m0_rvalid", m0_rvalid_o, e.rv0);
          chk("m1_rvalid", m1_rvalid_o, e.rv1);
          if (e.rv0) chk("m0_rdata", m0_rdata_o, e.rdata);
          if (e.rv1) chk("m1_rdata", m1_rdata_o, e.rdata);
          chk("err", err_o, e.err);
          chk("cnt_m0", cnt_m0_o, e.c0);
          chk("cnt_m1", cnt_m1_o, e.c1);
        end
      end
    end
  end

  task automatic do_reset();
    tick(); idle(); rst_ni = 1'b0; predict();
    tick(); rst_ni = 1'b1; idle(); predict();
  endtask

  bit          p_val[2];
  logic [31:0] p_addr[2], p_wd[2];
  bit          p_we[2];
  logic [3:0]  p_be[2];

  initial begin
    idle();
    rst_ni = 1'b0;
    m_rr = 0; m_lock = 0; m_lock_id = 0; m_err = 0; m_c0 = 0; m_c1 = 0;
    do_reset();

    // m0 write with immediate grant, response next cycle
    tick(); m0_req_i = 1'b1; m0_addr_i = 32'h100; m0_we_i = 1'b1; m0_be_i = 4'hF;
    m0_wdata_i = 32'hDEADBEEF; s_gnt_i = 1'b1; predict();
    tick(); idle(); s_rvalid_i = 1'b1; s_rdata_i = 32'h1234_5678; predict();
    tick(); idle(); predict();

    // both masters request continuously; grants alternate, responses follow one cycle later
    for (int i = 0; i < 8; i++) begin
      tick(); idle();
      m0_req_i = 1'b1; m1_req_i = 1'b1; s_gnt_i = 1'b1;
      m0_addr_i = 32'h2000 + 32'(i); m1_addr_i = 32'h3000 + 32'(i);
      s_rvalid_i = (i > 0); s_rdata_i = 32'hA000 + 32'(i); predict();
    end
    tick(); idle(); s_rvalid_i = 1'b1; s_rdata_i = 32'hBEEF; predict();

    // m1 stalled by the slave keeps the port while m0 joins
    for (int i = 0; i < 4; i++) begin
      tick(); idle();
      m1_req_i = 1'b1; m1_addr_i = 32'h4444; m0_req_i = (i > 0); m0_addr_i = 32'h5555;
      s_gnt_i = (i == 3); predict();
    end
    tick(); idle(); m0_req_i = 1'b1; m0_addr_i = 32'h5555; s_gnt_i = 1'b1; predict();
    tick(); idle(); s_rvalid_i = 1'b1; predict();
    tick(); idle(); s_rvalid_i = 1'b1; predict();

    // fill the ID FIFO, third request blocked, a response frees a slot next cycle
    do_reset();
    tick(); idle(); m0_req_i = 1'b1; m0_addr_i = 32'h10; s_gnt_i = 1'b1; predict();
    tick(); idle(); m1_req_i = 1'b1; m1_addr_i = 32'h20; s_gnt_i = 1'b1; predict();
    tick(); idle(); m0_req_i = 1'b1; m0_addr_i = 32'h30; s_gnt_i = 1'b1; predict();
    tick(); s_rvalid_i = 1'b1; s_rdata_i = 32'h77; predict();
    tick(); s_rvalid_i = 1'b0; predict();
    @(negedge clk_i);
    chk("resume_after_pop", m0_gnt_o, 1'b1);

    // reset with two outstanding, then an orphan response must raise the sticky error
    do_reset();
    tick(); idle(); s_rvalid_i = 1'b1; predict();
    for (int i = 0; i < 3; i++) begin tick(); idle(); predict(); end
    @(negedge clk_i);
    chk("err_sticky", err_o, 1'b1);
    chk("orphan_no_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b00);
    do_reset();
    @(negedge clk_i);
    chk("err_cleared", err_o, 1'b0);

    // five grants to m0 from a clean reset
    for (int i = 0; i < 5; i++) begin
      tick(); idle(); m0_req_i = 1'b1; m0_addr_i = 32'h600 + 32'(i); s_gnt_i = 1'b1;
      s_rvalid_i = (i > 0); predict();
    end
    tick(); idle(); s_rvalid_i = 1'b1; predict();
    @(negedge clk_i);
    chk("cnt_m0_five", cnt_m0_o, CNT_EN ? 32'd5 : 32'd0);

    // randomized traffic with OBI-stable masters that occasionally withdraw
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick();
      for (int n = 0; n < 2; n++) begin
        if (p_val[n] && $urandom_range(0, 15) == 0) p_val[n] = 1'b0;
        else if (!p_val[n] && $urandom_range(0, 99) < 55) begin
          p_val[n] = 1'b1; p_addr[n] = $urandom; p_wd[n] = $urandom;
          p_we[n] = 1'($urandom); p_be[n] = 4'($urandom);
        end
      end
      m0_req_i = p_val[0]; m0_addr_i = p_addr[0]; m0_we_i = p_we[0]; m0_be_i = p_be[0]; m0_wdata_i = p_wd[0];
      m1_req_i = p_val[1]; m1_addr_i = p_addr[1]; m1_we_i = p_we[1]; m1_be_i = p_be[1]; m1_wdata_i = p_wd[1];
      s_gnt_i = ($urandom_range(0, 3) != 0);
      s_rvalid_i = (outq.size() > 0) && ($urandom_range(0, 1) == 1);
      s_rdata_i = $urandom;
      predict();
      if (last_g0) p_val[0] = 1'b0;
      if (last_g1) p_val[1] = 1'b0;
    end

    tick(); idle(); predict();
    repeat (2) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
